// File: rtl/uart_transceiver.sv
`timescale 1ns/1ps
// uart_transceiver
// Single-clock UART transmitter/receiver pair with an internal bit-rate divider.
// TX serialises tx_data LSB first: start bit, data, optional parity, 1 or 2 stop bits.
// RX synchronises the line, samples each bit at its mid-point, rejects false starts,
// and reports parity/framing errors together with the received word.
//
// Parameters: DATA_LENGTH (5..9), PARITY_EN (0/1), STOP_BITS (1/2), CLK_DIV (>=4)
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   tx_data       word to transmit        tx_valid / tx_ready  transmit handshake
//   parity_type   0 = even, 1 = odd       tx_serialout         serial line, idle high
//   tx_busy       frame in progress       rx_serialin          asynchronous serial input
//   rx_data       last received word      rx_valid             one-cycle new-word pulse
//   parity_error  parity mismatch         frame_error          a stop bit sampled low
// Optional feature: define UART_TRANSCEIVER_LOOPBACK_EN to add input `loopback`,
// which routes tx_serialout into the RX synchroniser instead of rx_serialin.
module uart_transceiver #(
    parameter int DATA_LENGTH = 8,
    parameter int PARITY_EN   = 0,
    parameter int STOP_BITS   = 1,
    parameter int CLK_DIV     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef UART_TRANSCEIVER_LOOPBACK_EN
    input  logic                   loopback,
`endif
    input  logic [DATA_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic                   parity_type,
    output logic                   tx_serialout,
    output logic                   tx_busy,
    input  logic                   rx_serialin,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   parity_error,
    output logic                   frame_error
);

    localparam int                 CNT_W      = $clog2(CLK_DIV);
    localparam int                 IDX_W      = 4;
    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLK_DIV - 32'sd1);
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'((CLK_DIV / 32'sd2) - 32'sd1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DATA_LENGTH - 32'sd1);
    localparam logic               STOP_LAST  = 1'(STOP_BITS - 32'sd1);
    localparam logic               HAS_PARITY = (PARITY_EN != 32'sd0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } state_t;

    // Parity bit for a word: even -> XOR of bits, odd -> its complement.
    function automatic logic calc_parity(input logic [DATA_LENGTH-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    // ---------------- transmitter ----------------
    state_t                 tx_state_r;
    logic [CNT_W-1:0]       tx_cnt_r;
    logic [IDX_W-1:0]       tx_idx_r;
    logic                   tx_stop_r;
    logic [DATA_LENGTH-1:0] tx_sh_r;
    logic                   tx_par_r;
    logic                   tx_line_r;
    logic                   tx_ready_r;
    logic                   tx_busy_r;

    // TX frame sequencer; the line level is registered one edge ahead of each bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= '0;
            tx_idx_r   <= '0;
            tx_stop_r  <= 1'b0;
            tx_sh_r    <= '0;
            tx_par_r   <= 1'b0;
            tx_line_r  <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    if (tx_valid) begin
                        tx_sh_r    <= tx_data;
                        tx_par_r   <= calc_parity(tx_data, parity_type);
                        tx_line_r  <= 1'b0;
                        tx_cnt_r   <= '0;
                        tx_ready_r <= 1'b0;
                        tx_busy_r  <= 1'b1;
                        tx_state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx_idx_r   <= '0;
                        tx_line_r  <= tx_sh_r[0];
                        tx_state_r <= ST_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_idx_r == IDX_LAST) begin
                            if (HAS_PARITY) begin
                                tx_line_r  <= tx_par_r;
                                tx_state_r <= ST_PARITY;
                            end else begin
                                tx_line_r  <= 1'b1;
                                tx_stop_r  <= 1'b0;
                                tx_state_r <= ST_STOP;
                            end
                        end else begin
                            tx_idx_r  <= tx_idx_r + 1'b1;
                            tx_sh_r   <= {1'b0, tx_sh_r[DATA_LENGTH-1:1]};
                            tx_line_r <= tx_sh_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx_line_r  <= 1'b1;
                        tx_stop_r  <= 1'b0;
                        tx_state_r <= ST_STOP;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_stop_r == STOP_LAST) begin
                            tx_ready_r <= 1'b1;
                            tx_busy_r  <= 1'b0;
                            tx_state_r <= ST_IDLE;
                        end else begin
                            tx_stop_r <= 1'b1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 1'b1;
                    end
                end
                default: begin
                    tx_line_r  <= 1'b1;
                    tx_ready_r <= 1'b1;
                    tx_busy_r  <= 1'b0;
                    tx_state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_serialout = tx_line_r;
    assign tx_ready     = tx_ready_r;
    assign tx_busy      = tx_busy_r;

    // ---------------- receiver ----------------
    logic rx_in_s;
`ifdef UART_TRANSCEIVER_LOOPBACK_EN
    assign rx_in_s = loopback ? tx_line_r : rx_serialin;
`else
    assign rx_in_s = rx_serialin;
`endif

    logic rx_sync1_r;
    logic rx_sync2_r;
    logic rxs_s;

    // Two-flop synchroniser; reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
        end else begin
            rx_sync1_r <= rx_in_s;
            rx_sync2_r <= rx_sync1_r;
        end
    end

    assign rxs_s = rx_sync2_r;

    state_t                 rx_state_r;
    logic [CNT_W-1:0]       rx_cnt_r;
    logic [IDX_W-1:0]       rx_idx_r;
    logic                   rx_stop_r;
    logic [DATA_LENGTH-1:0] rx_sh_r;
    logic                   rx_perr_acc_r;
    logic                   rx_ferr_acc_r;
    logic [DATA_LENGTH-1:0] rx_data_r;
    logic                   rx_valid_r;
    logic                   parity_error_r;
    logic                   frame_error_r;

    // RX frame sequencer: half-bit start check, then one sample every CLK_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r     <= ST_IDLE;
            rx_cnt_r       <= '0;
            rx_idx_r       <= '0;
            rx_stop_r      <= 1'b0;
            rx_sh_r        <= '0;
            rx_perr_acc_r  <= 1'b0;
            rx_ferr_acc_r  <= 1'b0;
            rx_data_r      <= '0;
            rx_valid_r     <= 1'b0;
            parity_error_r <= 1'b0;
            frame_error_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                ST_IDLE: begin
                    if (!rxs_s) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r <= '0;
                        if (rxs_s) begin
                            // Line went back high before mid-start: a glitch, not a frame.
                            rx_state_r <= ST_IDLE;
                        end else begin
                            rx_idx_r      <= '0;
                            rx_perr_acc_r <= 1'b0;
                            rx_ferr_acc_r <= 1'b0;
                            rx_state_r    <= ST_DATA;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r <= '0;
                        rx_sh_r  <= {rxs_s, rx_sh_r[DATA_LENGTH-1:1]};
                        if (rx_idx_r == IDX_LAST) begin
                            rx_stop_r  <= 1'b0;
                            rx_state_r <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r      <= '0;
                        rx_perr_acc_r <= rxs_s ^ calc_parity(rx_sh_r, parity_type);
                        rx_stop_r     <= 1'b0;
                        rx_state_r    <= ST_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r <= '0;
                        if (rx_stop_r == STOP_LAST) begin
                            rx_data_r      <= rx_sh_r;
                            parity_error_r <= rx_perr_acc_r;
                            frame_error_r  <= rx_ferr_acc_r | ~rxs_s;
                            rx_valid_r     <= 1'b1;
                            // A low final stop means a break: wait for the line to recover.
                            rx_state_r     <= rxs_s ? ST_IDLE : ST_BRK;
                        end else begin
                            rx_ferr_acc_r <= rx_ferr_acc_r | ~rxs_s;
                            rx_stop_r     <= 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                ST_BRK: begin
                    if (rxs_s) begin
                        rx_state_r <= ST_IDLE;
                    end
                end
                default: begin
                    rx_state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign parity_error = parity_error_r;
    assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
// Testbench for uart_transceiver: instance A is 8N1, instance B is 8 data bits,
// parity enabled, two stop bits; both divide by 16.
module tb_uart_transceiver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] tx_data_a, tx_data_b, rxd_a, rxd_b;
    logic tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b, ptype_a, ptype_b;
    logic txo_a, txo_b, busy_a, busy_b, drv_a, drv_b, rxi_b, ext_loop_b;
    logic rxv_a, rxv_b, perr_a, perr_b, ferr_a, ferr_b;
    logic loopback_a, loopback_b;

    assign rxi_b = ext_loop_b ? txo_b : drv_b;

    uart_transceiver #(.DATA_LENGTH(8), .PARITY_EN(0), .STOP_BITS(1), .CLK_DIV(16)) dut_a (
        .clk(clk), .rst(rst),
`ifdef UART_TRANSCEIVER_LOOPBACK_EN
        .loopback(loopback_a),
`endif
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .parity_type(ptype_a), .tx_serialout(txo_a), .tx_busy(busy_a),
        .rx_serialin(drv_a), .rx_data(rxd_a), .rx_valid(rxv_a),
        .parity_error(perr_a), .frame_error(ferr_a)
    );

    uart_transceiver #(.DATA_LENGTH(8), .PARITY_EN(1), .STOP_BITS(2), .CLK_DIV(16)) dut_b (
        .clk(clk), .rst(rst),
`ifdef UART_TRANSCEIVER_LOOPBACK_EN
        .loopback(loopback_b),
`endif
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .parity_type(ptype_b), .tx_serialout(txo_b), .tx_busy(busy_b),
        .rx_serialin(rxi_b), .rx_data(rxd_b), .rx_valid(rxv_b),
        .parity_error(perr_b), .frame_error(ferr_b)
    );

    int errors = 0;
    int checks = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    logic flag_seen_b = 1'b0;
    logic [7:0] cap_q_b [$];

    // Count rx_valid pulses and record what each one delivered.
    always @(negedge clk) begin
        if (rxv_a === 1'b1) pulses_a <= pulses_a + 1;
        if (rxv_b === 1'b1) begin
            pulses_b <= pulses_b + 1;
            cap_q_b.push_back(rxd_b);
            if (perr_b || ferr_b) flag_seen_b <= 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive n serial bits (bit 0 first) for 16 cycles each; called at a negedge.
    task automatic drive_bits(input bit sel_b, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_b) drv_b = bits[i]; else drv_a = bits[i];
            repeat (16) @(negedge clk);
        end
        if (sel_b) drv_b = 1'b1; else drv_a = 1'b1;
    endtask

    // Send one word and check the line at the start and end of every bit period.
    task automatic tx_frame(input bit sel_b, input logic [7:0] d, input logic [15:0] exp_bits,
                            input int nbits, input string tag);
        int waitc;
        int ready_bad;
        logic rdy, line;
        waitc = 0;
        ready_bad = 0;
        rdy = sel_b ? tx_ready_b : tx_ready_a;
        while (rdy !== 1'b1 && waitc < 1000) begin
            @(negedge clk);
            waitc++;
            rdy = sel_b ? tx_ready_b : tx_ready_a;
        end
        check1({tag, " ready_wait"}, 32'(rdy), 32'd1);
        if (sel_b) begin tx_data_b = d; tx_valid_b = 1'b1; end
        else begin tx_data_a = d; tx_valid_a = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        // Deassert and scramble tx_data: changes while busy must be ignored.
        if (sel_b) begin tx_valid_b = 1'b0; tx_data_b = ~d; end
        else begin tx_valid_a = 1'b0; tx_data_a = ~d; end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 16; c++) begin
                rdy  = sel_b ? tx_ready_b : tx_ready_a;
                line = sel_b ? txo_b : txo_a;
                if (rdy !== 1'b0) ready_bad++;
                if (c == 0 || c == 15)
                    check1($sformatf("%s bit%0d c%0d", tag, b, c), 32'(line), 32'(exp_bits[b]));
                @(negedge clk);
            end
        end
        rdy  = sel_b ? tx_ready_b : tx_ready_a;
        line = sel_b ? txo_b : txo_a;
        check1({tag, " ready_low_cycles"}, 32'(ready_bad), 32'd0);
        check1({tag, " ready_back"}, 32'(rdy), 32'd1);
        check1({tag, " line_idle"}, 32'(line), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [15:0] bits;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ptype;
        logic       par_bit;
        logic [1:0] stops;      // bit 0 = first stop, bit 1 = second stop
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;

    tx_vec_t txv [4];
    rx_vec_t rxv [6];

    initial begin
        int p0;
        txv[0] = '{8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}};
        txv[1] = '{8'h00, {6'b0, 1'b1, 8'h00, 1'b0}};
        txv[2] = '{8'hFF, {6'b0, 1'b1, 8'hFF, 1'b0}};
        txv[3] = '{8'h3C, {6'b0, 1'b1, 8'h3C, 1'b0}};
        rxv[0] = '{8'h03, 1'b1, 1'b1, 2'b11, 8'h03, 1'b0, 1'b0};
        rxv[1] = '{8'h03, 1'b1, 1'b0, 2'b11, 8'h03, 1'b1, 1'b0};
        rxv[2] = '{8'h5A, 1'b0, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0};
        rxv[3] = '{8'h80, 1'b0, 1'b1, 2'b01, 8'h80, 1'b0, 1'b1};
        rxv[4] = '{8'hFF, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b0, 1'b1};
        rxv[5] = '{8'h11, 1'b0, 1'b0, 2'b11, 8'h11, 1'b0, 1'b0};

        rst = 1'b0;
        tx_valid_a = 1'b1; tx_data_a = 8'hFF; tx_valid_b = 1'b0; tx_data_b = 8'h00;
        ptype_a = 1'b0; ptype_b = 1'b0; drv_a = 1'b1; drv_b = 1'b1; ext_loop_b = 1'b0;
        loopback_a = 1'b0; loopback_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values (tx_valid held high during reset must not be accepted).
        check1("rst tx_serialout", 32'(txo_a), 32'd1);
        check1("rst tx_ready", 32'(tx_ready_a), 32'd1);
        check1("rst tx_busy", 32'(busy_a), 32'd0);
        check1("rst rx_data", 32'(rxd_a), 32'd0);
        check1("rst rx_valid", 32'(rxv_a), 32'd0);
        check1("rst parity_error", 32'(perr_a), 32'd0);
        check1("rst frame_error", 32'(ferr_a), 32'd0);
        tx_valid_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check1("post-rst tx_ready", 32'(tx_ready_a), 32'd1);
        check1("post-rst tx_serialout", 32'(txo_a), 32'd1);

        // TX frames, 8N1.
        for (int i = 0; i < 4; i++)
            tx_frame(1'b0, txv[i].d, txv[i].bits, 10, $sformatf("txA[%0d]", i));

        // TX with odd parity and two stop bits: 0x03 -> parity bit 1.
        ptype_b = 1'b1;
        tx_frame(1'b1, 8'h03, {4'b0, 2'b11, 1'b1, 8'h03, 1'b0}, 12, "txB odd");

        // RX vectors on instance B.
        for (int i = 0; i < 6; i++) begin
            ptype_b = rxv[i].ptype;
            p0 = pulses_b;
            drive_bits(1'b1, {4'b0, rxv[i].stops, rxv[i].par_bit, rxv[i].data, 1'b0}, 12);
            repeat (16) @(negedge clk);
            check1($sformatf("rxB[%0d] pulses", i), 32'(pulses_b - p0), 32'd1);
            check1($sformatf("rxB[%0d] data", i), 32'(rxd_b), 32'(rxv[i].exp_data));
            check1($sformatf("rxB[%0d] parity_error", i), 32'(perr_b), 32'(rxv[i].exp_perr));
            check1($sformatf("rxB[%0d] frame_error", i), 32'(ferr_b), 32'(rxv[i].exp_ferr));
        end

        // False start: 4-cycle low glitch yields nothing, then 0x11 is received.
        p0 = pulses_a;
        drv_a = 1'b0;
        repeat (4) @(negedge clk);
        drv_a = 1'b1;
        repeat (40) @(negedge clk);
        check1("glitch no pulse", 32'(pulses_a - p0), 32'd0);
        drive_bits(1'b0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        repeat (16) @(negedge clk);
        check1("after glitch pulses", 32'(pulses_a - p0), 32'd1);
        check1("after glitch data", 32'(rxd_a), 32'h11);
        check1("after glitch frame_error", 32'(ferr_a), 32'd0);

        // Break: line low for three frame times gives exactly one frame.
        p0 = pulses_a;
        drv_a = 1'b0;
        repeat (480) @(negedge clk);
        check1("break pulses", 32'(pulses_a - p0), 32'd1);
        check1("break data", 32'(rxd_a), 32'h00);
        check1("break frame_error", 32'(ferr_a), 32'd1);
        drv_a = 1'b1;
        repeat (32) @(negedge clk);
        check1("break recover pulses", 32'(pulses_a - p0), 32'd1);
        check1("break flag hold", 32'(ferr_a), 32'd1);
        drive_bits(1'b0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10);
        repeat (16) @(negedge clk);
        check1("post-break pulses", 32'(pulses_a - p0), 32'd2);
        check1("post-break data", 32'(rxd_a), 32'h7E);
        check1("post-break frame_error", 32'(ferr_a), 32'd0);

        // Loopback, even parity, two stop bits, back-to-back 0x5A then 0xC3.
        ptype_b = 1'b0;
`ifdef UART_TRANSCEIVER_LOOPBACK_EN
        loopback_b = 1'b1;
`else
        ext_loop_b = 1'b1;
`endif
        repeat (4) @(negedge clk);
        p0 = pulses_b;
        cap_q_b.delete();
        flag_seen_b = 1'b0;
        tx_frame(1'b1, 8'h5A, {4'b0, 2'b11, 1'b0, 8'h5A, 1'b0}, 12, "loop 5A");
        tx_frame(1'b1, 8'hC3, {4'b0, 2'b11, 1'b0, 8'hC3, 1'b0}, 12, "loop C3");
        repeat (24) @(negedge clk);
        check1("loop pulses", 32'(pulses_b - p0), 32'd2);
        check1("loop first", 32'(cap_q_b.size() > 0 ? cap_q_b[0] : 8'hxx), 32'h5A);
        check1("loop second", 32'(cap_q_b.size() > 1 ? cap_q_b[1] : 8'hxx), 32'hC3);
        check1("loop flags", 32'(flag_seen_b), 32'd0);

        // Reset in the middle of the TX data bits.
        tx_data_b = 8'h77;
        tx_valid_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid_b = 1'b0;
        repeat (40) @(negedge clk);
        p0 = pulses_b;
        check1("pre-reset line low period busy", 32'(busy_b), 32'd1);
        #2 rst = 1'b0;
        #1;
        check1("async rst tx_serialout", 32'(txo_b), 32'd1);
        check1("async rst tx_ready", 32'(tx_ready_b), 32'd1);
        check1("async rst tx_busy", 32'(busy_b), 32'd0);
        check1("async rst rx_data", 32'(rxd_b), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (250) @(negedge clk);
        check1("rst no partial pulse", 32'(pulses_b - p0), 32'd0);
        tx_frame(1'b1, 8'h3C, {4'b0, 2'b11, 1'b0, 8'h3C, 1'b0}, 12, "post-rst 3C");
        repeat (24) @(negedge clk);
        check1("post-rst pulses", 32'(pulses_b - p0), 32'd1);
        check1("post-rst data", 32'(rxd_b), 32'h3C);
        check1("post-rst parity_error", 32'(perr_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
